// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the PC register and decode.
//
// Captures PC_in, issues one instruction-memory read at a time over a req/ack
// handshake and buffers returned {address, word} pairs in a DEPTH-entry FIFO
// presented to decode as valid/ready. A taken branch (flush) empties the queue
// and kills any outstanding fetch; a fetch already on the bus is drained in a
// drop phase so the memory handshake stays well formed.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN): when the queue is empty
// an acknowledged word is forwarded to decode in the ack cycle and is not
// queued if decode accepts it.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   PC_in               fetch address from the PC stage
//   flush               taken branch; discard queue and outstanding fetch
//   pc_stall            PC stage must hold its value this cycle
//   imem_req/imem_addr  memory read request, held until imem_ack
//   imem_ack/imem_rdata single-cycle read response
//   instr_valid/instr_ready/instr_out/instr_pc  head entry towards decode
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC_in,
  input  logic            flush,
  output logic            pc_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]   pc_mem_q  [DEPTH];
  logic [XLEN-1:0]   ins_mem_q [DEPTH];

  logic empty, full, capture, push, pop, byp_valid, byp_taken;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // Capturing only below full with a single outstanding fetch reserves the
  // slot the response will land in, so a push can never overflow.
  assign capture  = (state_q == StIdle) && !full && !flush;
  assign pc_stall = !capture;

  // The request is outstanding in both WAIT and DROP.
  assign imem_req  = (state_q != StIdle);
  assign imem_addr = addr_q;

`ifdef FETCH_BYPASS_EN
  assign byp_valid = empty && (state_q == StWait) && imem_ack && !flush;
`else
  assign byp_valid = 1'b0;
`endif
  assign byp_taken = byp_valid && instr_ready;

  assign pop  = !empty && instr_ready && !flush;
  assign push = (state_q == StWait) && imem_ack && !flush && !byp_taken;

  always_comb begin
    instr_valid = !empty || byp_valid;
    instr_out   = '0;
    instr_pc    = '0;
    if (!empty) begin
      instr_out = ins_mem_q[rd_ptr_q];
      instr_pc  = pc_mem_q[rd_ptr_q];
    end else if (byp_valid) begin
      instr_out = imem_rdata;
      instr_pc  = addr_q;
    end
  end

  // Fetch FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          addr_d  = PC_in;
          state_d = StWait;
        end
      end
      StWait: begin
        // A flush coinciding with ack just drops the word (push is gated).
        if (imem_ack) begin
          state_d = StIdle;
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Queue bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]  <= addr_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: transaction-level model (queue of fetched words, an
// outstanding/dropping flag pair) checked against the DUT every cycle, a
// randomized-latency memory, directed scenarios with literal expectations and
// a long randomized run.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
`ifdef FETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] PC_in;
  logic            flush;
  logic            pc_stall;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .PC_in      (PC_in),
    .flush      (flush),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model state
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          m_busy, m_drop;
  logic [31:0] m_addr;

  // Memory model
  int          mem_wait, mem_lat, fixed_lat;
  bit          use_fixed;
  logic [31:0] fixed_rdata;

  // DUT samples for directed checks
  logic        s_stall, s_valid, s_req;
  logic [31:0] s_out, s_pc, s_addr;
  logic [31:0] dut_pops[$];

  task automatic model_reset();
    q_pc.delete();
    q_ins.delete();
    m_busy   = 1'b0;
    m_drop   = 1'b0;
    m_addr   = '0;
    mem_wait = 0;
  endtask

  // One clock: drive at negedge, compare #1 later, advance model at posedge.
  task automatic cycle(input logic [31:0] pc, input logic fl, input logic rdy);
    bit          take, byp;
    logic [31:0] e_out, e_pc;
    @(negedge clk);
    PC_in       = pc;
    flush       = fl;
    instr_ready = rdy;
    imem_ack    = 1'b0;
    if (imem_req) begin
      if (mem_wait == 0) mem_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
      mem_wait++;
      if (mem_wait >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = use_fixed ? fixed_rdata : $urandom;
        mem_wait   = 0;
      end
    end else begin
      mem_wait = 0;
    end
    #1;
    take  = !m_busy && (q_pc.size() < DEPTH) && !fl;
    byp   = Byp && (q_pc.size() == 0) && m_busy && !m_drop && imem_ack && !fl;
    e_out = '0;
    e_pc  = '0;
    if (q_pc.size() != 0) begin
      e_out = q_ins[0];
      e_pc  = q_pc[0];
    end else if (byp) begin
      e_out = imem_rdata;
      e_pc  = m_addr;
    end
    chk("pc_stall", pc_stall, !take);
    chk("imem_req", imem_req, m_busy);
    chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", instr_valid, (q_pc.size() != 0) || byp);
    chk("instr_out", instr_out, e_out);
    chk("instr_pc", instr_pc, e_pc);
    s_stall = pc_stall;
    s_valid = instr_valid;
    s_req   = imem_req;
    s_out   = instr_out;
    s_pc    = instr_pc;
    s_addr  = imem_addr;
    if (instr_valid && rdy && !fl) dut_pops.push_back(instr_pc);
    @(posedge clk);
    if (fl) begin
      q_pc.delete();
      q_ins.delete();
      if (m_busy && imem_ack) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else if (m_busy) begin
        m_drop = 1'b1;
      end
    end else begin
      if (q_pc.size() != 0 && rdy) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (m_busy && imem_ack) begin
        if (!m_drop && !(byp && rdy)) begin
          q_pc.push_back(m_addr);
          q_ins.push_back(imem_rdata);
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
    end
    if (take) begin
      m_busy = 1'b1;
      m_addr = pc;
    end
  endtask

  // Flush until no fetch is outstanding, leaving an empty idle queue.
  task automatic settle();
    cycle(0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && m_busy; i++) cycle(0, 1'b1, 1'b1);
    cycle(0, 1'b1, 1'b1);
    chk("settle_idle", s_req, 1'b0);
  endtask

  logic [31:0] pc;
  bit          fl;

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    PC_in       = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    use_fixed   = 1'b1;
    fixed_rdata = 32'h0000_0013;
    fixed_lat   = 1;
    mem_lat     = 1;
    model_reset();
    #12;
    chk("rst_pc_stall", pc_stall, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;

    // 1-cycle memory returning 0x13, PC_in=0, ready=1
    cycle(0, 1'b0, 1'b1);
    chk("s1_stall_c0", s_stall, 1'b0);
    cycle(0, 1'b0, 1'b1);
    chk("s1_stall_c1", s_stall, 1'b1);
    chk("s1_req_c1", s_req, 1'b1);
    chk("s1_addr_c1", s_addr, 32'h0);
`ifdef FETCH_BYPASS_EN
    chk("s1_byp_valid", s_valid, 1'b1);
    chk("s1_byp_out", s_out, 32'h13);
`else
    chk("s1_valid_c1", s_valid, 1'b0);
`endif
    cycle(0, 1'b0, 1'b1);
    chk("s1_stall_c2", s_stall, 1'b0);
`ifdef FETCH_BYPASS_EN
    chk("s1_valid_c2", s_valid, 1'b0);
`else
    chk("s1_valid_c2", s_valid, 1'b1);
    chk("s1_out_c2", s_out, 32'h13);
    chk("s1_pc_c2", s_pc, 32'h0);
`endif
    cycle(0, 1'b0, 1'b1);
    chk("s1_stall_c3", s_stall, 1'b1);

    // Fill with ready=0, then drain in order
    settle();
    pc = 4;
    for (int i = 0; i < 12; i++) begin
      cycle(pc, 1'b0, 1'b0);
      if (!s_stall) pc += 4;
    end
    chk("s2_full_stall", s_stall, 1'b1);
    chk("s2_head_pc", s_pc, 32'd4);
    chk("s2_pc_held", pc, 32'd20);
    dut_pops.delete();
    for (int i = 0; i < 40 && dut_pops.size() < 5; i++) begin
      cycle(pc, 1'b0, 1'b1);
      if (!s_stall) pc += 4;
    end
    chk("s2_npops", dut_pops.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("s2_order", (k < dut_pops.size()) ? dut_pops[k] : 32'hFFFF_FFFF, 32'(4 + 4 * k));
    end

    // 3-cycle memory, flush in the 2nd WAIT cycle
    settle();
    fixed_lat = 3;
    cycle(40, 1'b0, 1'b1);
    chk("s3_capture", s_stall, 1'b0);
    cycle(40, 1'b0, 1'b1);
    cycle(40, 1'b1, 1'b1);
    cycle(44, 1'b0, 1'b1);
    chk("s3_drop_req", s_req, 1'b1);
    chk("s3_drop_stall", s_stall, 1'b1);
    cycle(44, 1'b0, 1'b1);
    chk("s3_empty", s_valid, 1'b0);
    chk("s3_recapture", s_stall, 1'b0);
    cycle(44, 1'b0, 1'b1);
    chk("s3_addr44", s_addr, 32'd44);

    // Flush coinciding with a pop at count=2
    settle();
    fixed_lat = 1;
    pc = 60;
    for (int i = 0; i < 20 && q_pc.size() < 2; i++) begin
      cycle(pc, 1'b0, 1'b0);
      if (!s_stall) pc += 4;
    end
    cycle(pc, 1'b1, 1'b1);
    chk("s4_valid_at_flush", s_valid, 1'b1);
    chk("s4_head_pc", s_pc, 32'd60);
    cycle(pc, 1'b0, 1'b0);
    chk("s4_empty_after", s_valid, 1'b0);

    // Wrap: 10 instructions with ready toggling every cycle
    settle();
    pc = 100;
    dut_pops.delete();
    for (int i = 0; i < 200 && dut_pops.size() < 10; i++) begin
      cycle(pc, 1'b0, i[0]);
      if (!s_stall) pc += 4;
    end
    chk("s5_npops", dut_pops.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk("s5_order", (k < dut_pops.size()) ? dut_pops[k] : 32'hFFFF_FFFF, 32'(100 + 4 * k));
    end

`ifdef FETCH_BYPASS_EN
    settle();
    fixed_rdata = 32'hDEAD_BEEF;
    cycle(200, 1'b0, 1'b1);
    cycle(204, 1'b0, 1'b1);
    chk("byp_valid", s_valid, 1'b1);
    chk("byp_out", s_out, 32'hDEAD_BEEF);
    chk("byp_pc", s_pc, 32'd200);
    cycle(204, 1'b0, 1'b1);
    chk("byp_not_queued", s_valid, 1'b0);
`endif

    // Randomized run with a mid-fetch reset
    use_fixed = 1'b0;
    fixed_lat = 0;
    pc = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < 3000; i++) begin
      fl = ($urandom_range(0, 19) == 0);
      cycle(pc, fl, 1'($urandom_range(0, 1)));
      if (fl) pc = $urandom & 32'hFFFF_FFFC;
      else if (!s_stall) pc += 4;
      if (i == 1500) begin
        for (int j = 0; j < 50 && !m_busy; j++) begin
          cycle(pc, 1'b0, 1'b0);
          if (!s_stall) pc += 4;
        end
        #3;
        reset = 1'b0;
        flush = 1'b1;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_valid", instr_valid, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
